// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: tracks the destination tags of the instructions
// in EX/MA/WB and derives stall, freeze, flush, bubble and forwarding selects
// for the instruction currently sitting in ID.
module pipeline_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rsa,
    input  logic [4:0]       i_id_rsb,
    input  logic             i_id_hz_rsa,
    input  logic             i_id_hz_rsb,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_wb_en,
    input  logic             i_id_ma_rd,
    input  logic             i_redirect,
    input  logic             i_mem_busy,
    output logic             o_stall,
    output logic             o_freeze,
    output logic             o_flush,
    output logic             o_bubble,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb_en;
        logic       ld;
    } tag_t;

    tag_t ex_q, ma_q, wb_q, id_tag;

    logic a_ex, a_ma, a_wb, b_ex, b_ma, b_wb;
    logic load_use, any_hit, raw;

    // x0 is hardwired zero, so a source of 0 never depends on a producer.
    function automatic logic hit(input tag_t t, input logic [4:0] s, input logic hz);
        return hz && (s != 5'd0) && t.valid && t.wb_en && (t.rd == s);
    endfunction

    // Youngest producer wins: EX holds the newest value, WB the oldest.
    function automatic logic [1:0] fwd_sel(input logic ex, input logic ma, input logic wb);
        if (ex)      return 2'b01;
        else if (ma) return 2'b10;
        else if (wb) return 2'b11;
        else         return 2'b00;
    endfunction

    assign id_tag = '{valid: 1'b1, rd: i_id_rd, wb_en: i_id_wb_en, ld: i_id_ma_rd};

    // Hazard detection and control outputs; freeze outranks flush outranks stall.
    always_comb begin
        a_ex     = hit(ex_q, i_id_rsa, i_id_hz_rsa);
        a_ma     = hit(ma_q, i_id_rsa, i_id_hz_rsa);
        a_wb     = hit(wb_q, i_id_rsa, i_id_hz_rsa);
        b_ex     = hit(ex_q, i_id_rsb, i_id_hz_rsb);
        b_ma     = hit(ma_q, i_id_rsb, i_id_hz_rsb);
        b_wb     = hit(wb_q, i_id_rsb, i_id_hz_rsb);
        load_use = ex_q.ld && (a_ex || b_ex);
        any_hit  = a_ex || a_ma || a_wb || b_ex || b_ma || b_wb;
        raw      = FWD_EN ? load_use : any_hit;

        o_freeze = i_mem_busy;
        o_flush  = i_redirect && !i_mem_busy;
        o_stall  = i_id_valid && raw && !i_mem_busy && !i_redirect;
        o_bubble = o_stall || o_flush;
        o_fwd_a  = FWD_EN ? fwd_sel(a_ex, a_ma, a_wb) : 2'b00;
        o_fwd_b  = FWD_EN ? fwd_sel(b_ex, b_ma, b_wb) : 2'b00;
    end

    // Advance the tag slots; a bubble or empty ID enters EX as an invalid slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q <= '0;
            ma_q <= '0;
            wb_q <= '0;
        end else if (!i_mem_busy) begin
            wb_q <= ma_q;
            ma_q <= ex_q;
            ex_q <= (i_id_valid && !o_bubble) ? id_tag : tag_t'('0);
        end
    end

    // Saturating count of lost cycles (stall or freeze).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_stall_cnt <= '0;
        else if ((o_stall || o_freeze) && (o_stall_cnt != {CNT_W{1'b1}}))
            o_stall_cnt <= o_stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: forwarding instance (default widths) and
// an interlock-only instance with a narrow counter, sharing one stimulus set.
module tb_pipeline_ctrl;

    logic       i_clk, i_rst_n;
    logic       i_id_valid, i_id_hz_rsa, i_id_hz_rsb, i_id_wb_en, i_id_ma_rd;
    logic [4:0] i_id_rsa, i_id_rsb, i_id_rd;
    logic       i_redirect, i_mem_busy;

    logic        f_stall, f_freeze, f_flush, f_bubble;
    logic [1:0]  f_fwd_a, f_fwd_b;
    logic [15:0] f_cnt;
    logic        n_stall, n_freeze, n_flush, n_bubble;
    logic [1:0]  n_fwd_a, n_fwd_b;
    logic [3:0]  n_cnt;

    int checks = 0;
    int failures = 0;

    pipeline_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dut_f (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid),
        .i_id_rsa(i_id_rsa), .i_id_rsb(i_id_rsb),
        .i_id_hz_rsa(i_id_hz_rsa), .i_id_hz_rsb(i_id_hz_rsb),
        .i_id_rd(i_id_rd), .i_id_wb_en(i_id_wb_en), .i_id_ma_rd(i_id_ma_rd),
        .i_redirect(i_redirect), .i_mem_busy(i_mem_busy),
        .o_stall(f_stall), .o_freeze(f_freeze), .o_flush(f_flush), .o_bubble(f_bubble),
        .o_fwd_a(f_fwd_a), .o_fwd_b(f_fwd_b), .o_stall_cnt(f_cnt)
    );

    pipeline_ctrl #(.FWD_EN(1'b0), .CNT_W(4)) dut_n (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid),
        .i_id_rsa(i_id_rsa), .i_id_rsb(i_id_rsb),
        .i_id_hz_rsa(i_id_hz_rsa), .i_id_hz_rsb(i_id_hz_rsb),
        .i_id_rd(i_id_rd), .i_id_wb_en(i_id_wb_en), .i_id_ma_rd(i_id_ma_rd),
        .i_redirect(i_redirect), .i_mem_busy(i_mem_busy),
        .o_stall(n_stall), .o_freeze(n_freeze), .o_flush(n_flush), .o_bubble(n_bubble),
        .o_fwd_a(n_fwd_a), .o_fwd_b(n_fwd_b), .o_stall_cnt(n_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rsa, input logic hza,
                          input logic [4:0] rsb, input logic hzb,
                          input logic [4:0] rd, input logic wb, input logic ld);
        i_id_valid = v; i_id_rsa = rsa; i_id_hz_rsa = hza;
        i_id_rsb = rsb; i_id_hz_rsb = hzb;
        i_id_rd = rd; i_id_wb_en = wb; i_id_ma_rd = ld;
    endtask

    // Advance one clock, land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reset pulse placed mid-cycle, away from the rising edge.
    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        i_redirect = 1'b0; i_mem_busy = 1'b0;
        #2;
        i_rst_n = 1'b1;
    endtask

    // Packed view of the forwarding-instance control outputs: {stall,freeze,flush,bubble}
    function automatic logic [3:0] fctl();
        return {f_stall, f_freeze, f_flush, f_bubble};
    endfunction

    initial begin
        i_rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        i_redirect = 1'b0; i_mem_busy = 1'b0;
        #12;
        chk("rst_f_ctl", {28'd0, fctl()}, 32'h0);
        chk("rst_f_fwd", {28'd0, f_fwd_a, f_fwd_b}, 32'h0);
        chk("rst_f_cnt", {16'd0, f_cnt}, 32'd0);
        chk("rst_n_ctl", {28'd0, n_stall, n_freeze, n_flush, n_bubble}, 32'h0);
        chk("rst_n_cnt", {28'd0, n_cnt}, 32'd0);
        #1 i_rst_n = 1'b1;

        // Load-use: load x5 then add reading x5 -> one stall, then forward from MA.
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        #1 chk("lu_prod_nostall", {31'd0, f_stall}, 32'd0);
        tick();
        set_id(1, 5, 1, 0, 0, 3, 1, 0);
        #1 chk("lu_stall_ctl", {28'd0, fctl()}, 32'b1001);
        tick();
        chk("lu_after_ctl", {28'd0, fctl()}, 32'b0000);
        chk("lu_after_fwda", {30'd0, f_fwd_a}, 32'b10);
        chk("lu_cnt", {16'd0, f_cnt}, 32'd1);

        // ALU chain with forwarding: EX, MA, WB selects; hz gating on an unread source.
        tick();                                     // EX=x3, WB=x5
        set_id(1, 0, 0, 0, 0, 7, 1, 0);
        tick();                                     // EX=x7, MA=x3
        set_id(1, 3, 1, 7, 1, 8, 1, 0);
        #1 chk("alu_nostall", {31'd0, f_stall}, 32'd0);
        chk("alu_fwdb_ex", {30'd0, f_fwd_b}, 32'b01);
        chk("alu_fwda_ma", {30'd0, f_fwd_a}, 32'b10);
        tick();                                     // EX=x8, MA=x7, WB=x3
        set_id(1, 3, 1, 8, 0, 9, 1, 0);
        #1 chk("alu_fwda_wb", {30'd0, f_fwd_a}, 32'b11);
        chk("alu_hz_gate", {30'd0, f_fwd_b}, 32'b00);

        // x0 never matches, even for a load writing x0.
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 1, 0, 1, 4, 1, 0);
        #1 chk("x0_f_ctl", {28'd0, fctl()}, 32'h0);
        chk("x0_f_fwd", {28'd0, f_fwd_a, f_fwd_b}, 32'h0);
        chk("x0_n_stall", {31'd0, n_stall}, 32'd0);

        // Load-use coincident with redirect, then with mem_busy.
        do_reset();
        set_id(1, 0, 0, 0, 0, 9, 1, 1);
        tick();
        set_id(1, 9, 1, 0, 0, 2, 1, 0);
        i_redirect = 1'b1;
        #1 chk("flush_ctl", {28'd0, fctl()}, 32'b0011);
        i_mem_busy = 1'b1;
        #1 chk("freeze_redir_ctl", {28'd0, fctl()}, 32'b0100);
        i_redirect = 1'b0;
        #1 chk("freeze_ctl", {28'd0, fctl()}, 32'b0100);
        tick();
        i_mem_busy = 1'b0;
        #1 chk("freeze_held_stall", {28'd0, fctl()}, 32'b1001);
        chk("freeze_cnt", {16'd0, f_cnt}, 32'd1);
        tick();
        chk("freeze_post_fwd", {30'd0, f_fwd_a}, 32'b10);
        chk("freeze_post_cnt", {16'd0, f_cnt}, 32'd2);

        // Interlock-only: ALU producer x7 stalls consumer for 3 cycles.
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0);
        tick();
        set_id(1, 0, 0, 7, 1, 8, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("il_stall%0d", k), {30'd0, n_stall, n_bubble}, 32'b11);
            chk($sformatf("il_fwd%0d", k), {30'd0, n_fwd_b}, 32'b00);
            tick();
        end
        #1 chk("il_release", {31'd0, n_stall}, 32'd0);
        chk("il_cnt", {28'd0, n_cnt}, 32'd3);

        // Counter saturation on the narrow instance: 2^4+5 freeze cycles.
        do_reset();
        i_mem_busy = 1'b1;
        repeat (21) tick();
        chk("sat_n_cnt", {28'd0, n_cnt}, 32'd15);
        chk("sat_f_cnt", {16'd0, f_cnt}, 32'd21);
        i_mem_busy = 1'b0;
        tick();
        chk("sat_n_hold", {28'd0, n_cnt}, 32'd15);

        // Reset between edges during a stall clears it immediately.
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 1, 0, 0, 6, 1, 0);
        i_mem_busy = 1'b1;
        tick();
        i_mem_busy = 1'b0;
        #1 chk("mid_stall_pre", {31'd0, f_stall}, 32'd1);
        chk("mid_cnt_pre", {16'd0, f_cnt}, 32'd1);
        i_rst_n = 1'b0;
        #1 chk("mid_rst_ctl", {28'd0, fctl()}, 32'h0);
        chk("mid_rst_cnt", {16'd0, f_cnt}, 32'd0);
        i_rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
